// File: rtl/perf_counter_bank.sv
// Sixteen saturating event counters with a sticky overflow flag per counter,
// a sequential clear-all sweep and a snapshot bank feeding the readout mux.
module perf_counter_bank #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           event_i,
  input  logic                  freeze,
  input  logic                  clr_valid,
  input  logic [3:0]            clr_idx,
  input  logic                  clr_all,
  input  logic                  snap,
  output logic [16*WIDTH-1:0]   counts,
  output logic [15:0]           ovf,
  output logic                  snap_valid,
  output logic                  busy
);

  typedef enum logic {
    RUN   = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [3:0]       sweep_idx;
  logic             sweep_active;
  logic [15:0]      clr_hit;
  logic [15:0]      at_max;
  logic [WIDTH-1:0] live [16];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // clr_all is only looked at in RUN, so a request during a sweep is dropped
  always_comb begin
    next_state = state;
    case (state)
      RUN: begin
        if (clr_all) begin
          next_state = SWEEP;
        end
      end
      SWEEP: begin
        if (sweep_idx == 4'd15) begin
          next_state = RUN;
        end
      end
      default: next_state = RUN;
    endcase
  end

  always_comb begin
    sweep_active = (state == SWEEP);
    busy         = (state == SWEEP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sweep_idx <= 4'd0;
    end else if (state == RUN) begin
      sweep_idx <= 4'd0;
    end else begin
      sweep_idx <= sweep_idx + 4'd1;
    end
  end

  // Sweep and single clears both zero the counter and its overflow flag
  always_comb begin
    clr_hit = '0;
    at_max  = '0;
    for (int i = 0; i < 16; i++) begin
      clr_hit[i] = (sweep_active && (sweep_idx == 4'(i))) ||
                   (clr_valid && (clr_idx == 4'(i)));
      at_max[i]  = &live[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        live[i] <= '0;
      end
      ovf <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (clr_hit[i]) begin
          live[i] <= '0;
          ovf[i]  <= 1'b0;
        end else if (!freeze && event_i[i]) begin
          if (at_max[i]) begin
            ovf[i] <= 1'b1;
          end else begin
            live[i] <= live[i] + WIDTH'(1);
          end
        end
      end
    end
  end

  // Snapshot captures pre-edge live values, so same-edge increments are excluded
  always_ff @(posedge clk) begin
    if (rst) begin
      counts     <= '0;
      snap_valid <= 1'b0;
    end else begin
      snap_valid <= snap;
      if (snap) begin
        for (int i = 0; i < 16; i++) begin
          counts[i*WIDTH +: WIDTH] <= live[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Drives a 32-bit and a 4-bit instance with identical stimulus and compares both
// against a per-edge behavioural model of the counter bank.
module tb_perf_counter_bank;

  logic          clk = 1'b0;
  logic          rst;
  logic          freeze;
  logic          clr_valid;
  logic          clr_all;
  logic          snap;
  logic [15:0]   event_i;
  logic [3:0]    clr_idx;

  logic [16*32-1:0] counts32;
  logic [16*4-1:0]  counts4;
  logic [15:0]      ovf32;
  logic [15:0]      ovf4;
  logic             sv32;
  logic             sv4;
  logic             busy32;
  logic             busy4;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m32 [16];
  logic [3:0]  m4  [16];
  logic [31:0] s32 [16];
  logic [3:0]  s4  [16];
  logic [15:0] mo32;
  logic [15:0] mo4;
  logic        msv;
  logic        msweep;
  int          mpos;

  always #5 clk = ~clk;

  perf_counter_bank #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .event_i(event_i), .freeze(freeze),
    .clr_valid(clr_valid), .clr_idx(clr_idx), .clr_all(clr_all), .snap(snap),
    .counts(counts32), .ovf(ovf32), .snap_valid(sv32), .busy(busy32)
  );

  perf_counter_bank #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .event_i(event_i), .freeze(freeze),
    .clr_valid(clr_valid), .clr_idx(clr_idx), .clr_all(clr_all), .snap(snap),
    .counts(counts4), .ovf(ovf4), .snap_valid(sv4), .busy(busy4)
  );

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Applies one clock edge's worth of behaviour using the inputs seen at that edge
  function automatic void model_edge();
    logic hit;
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m32[i] = '0; m4[i] = '0; s32[i] = '0; s4[i] = '0;
      end
      mo32 = '0; mo4 = '0; msv = 1'b0; msweep = 1'b0; mpos = 0;
      return;
    end
    msv = snap;
    if (snap) begin
      for (int i = 0; i < 16; i++) begin
        s32[i] = m32[i];
        s4[i]  = m4[i];
      end
    end
    for (int i = 0; i < 16; i++) begin
      hit = (msweep && mpos == i) || (clr_valid && clr_idx == 4'(i));
      if (hit) begin
        m32[i] = '0; m4[i] = '0; mo32[i] = 1'b0; mo4[i] = 1'b0;
      end else if (!freeze && event_i[i]) begin
        if (m32[i] == 32'hFFFF_FFFF) mo32[i] = 1'b1;
        else m32[i] = m32[i] + 32'd1;
        if (m4[i] == 4'hF) mo4[i] = 1'b1;
        else m4[i] = m4[i] + 4'd1;
      end
    end
    if (msweep) begin
      if (mpos == 15) msweep = 1'b0;
      else mpos = mpos + 1;
    end else if (clr_all) begin
      msweep = 1'b1;
      mpos   = 0;
    end
  endfunction

  task automatic set_idle();
    rst = 1'b0; freeze = 1'b0; clr_valid = 1'b0; clr_idx = 4'd0;
    clr_all = 1'b0; snap = 1'b0; event_i = 16'h0000;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b1; snap = 1'b1; event_i = 16'($urandom);
    tick();
    event_i = 16'($urandom);
    tick();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (counts32[i*32 +: 32] !== 32'd0 || counts4[i*4 +: 4] !== 4'd0) begin
        failures++;
        $display("[TB] FAIL reset_lane%0d: got %0d/%0d expected 0", i, counts32[i*32 +: 32], counts4[i*4 +: 4]);
      end
    end
    checks++;
    if (ovf32 !== 16'h0 || ovf4 !== 16'h0 || sv32 !== 1'b0 || sv4 !== 1'b0 || busy32 !== 1'b0 || busy4 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags: got ovf=%h/%h sv=%b/%b busy=%b/%b expected all 0", ovf32, ovf4, sv32, sv4, busy32, busy4);
    end
    set_idle();
  endtask

  task automatic test_counting();
    int exp;
    set_idle();
    event_i = 16'h0001;
    repeat (5) tick();
    event_i = 16'h8000;
    repeat (3) tick();
    event_i = 16'h0000;
    checks++;
    if (sv32 !== 1'b0 || sv4 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL count_sv_before: got %b/%b expected 0", sv32, sv4);
    end
    snap = 1'b1;
    tick();
    snap = 1'b0;
    checks++;
    if (sv32 !== 1'b1 || sv4 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL count_sv_pulse: got %b/%b expected 1", sv32, sv4);
    end
    for (int i = 0; i < 16; i++) begin
      exp = (i == 0) ? 5 : (i == 15) ? 3 : 0;
      checks++;
      if (counts32[i*32 +: 32] !== 32'(exp) || counts4[i*4 +: 4] !== 4'(exp)) begin
        failures++;
        $display("[TB] FAIL count_lane%0d: got %0d/%0d expected %0d", i, counts32[i*32 +: 32], counts4[i*4 +: 4], exp);
      end
    end
    tick();
    checks++;
    if (sv32 !== 1'b0 || sv4 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL count_sv_after: got %b/%b expected 0", sv32, sv4);
    end
  endtask

  task automatic test_saturation();
    int exp4;
    set_idle();
    for (int k = 1; k <= 20; k++) begin
      event_i = 16'h0004;
      snap    = 1'b1;
      tick();
      exp4 = (k - 1 > 15) ? 15 : k - 1;
      checks++;
      if (ovf4 !== ((k >= 16) ? 16'h0004 : 16'h0000) || ovf32 !== 16'h0000) begin
        failures++;
        $display("[TB] FAIL sat_ovf_k%0d: got %h/%h expected %h/0000", k, ovf4, ovf32, (k >= 16) ? 16'h0004 : 16'h0000);
      end
      checks++;
      if (counts4[2*4 +: 4] !== 4'(exp4) || counts32[2*32 +: 32] !== 32'(k - 1)) begin
        failures++;
        $display("[TB] FAIL sat_lane2_k%0d: got %0d/%0d expected %0d/%0d", k, counts4[2*4 +: 4], counts32[2*32 +: 32], exp4, k - 1);
      end
    end
    set_idle();
    clr_valid = 1'b1; clr_idx = 4'd2;
    tick();
    clr_valid = 1'b0;
    checks++;
    if (ovf4 !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL sat_clr_ovf: got %h expected 0000", ovf4);
    end
    snap = 1'b1;
    tick();
    snap = 1'b0;
    checks++;
    if (counts4[2*4 +: 4] !== 4'd0 || counts32[2*32 +: 32] !== 32'd0) begin
      failures++;
      $display("[TB] FAIL sat_clr_lane2: got %0d/%0d expected 0", counts4[2*4 +: 4], counts32[2*32 +: 32]);
    end
  endtask

  task automatic test_conflicts();
    int exp;
    set_idle();
    event_i = 16'h0008;
    repeat (7) tick();
    event_i = 16'h0000; snap = 1'b1;
    tick();
    snap = 1'b0;
    checks++;
    if (counts32[3*32 +: 32] !== 32'd7 || counts4[3*4 +: 4] !== 4'd7) begin
      failures++;
      $display("[TB] FAIL conf_preload3: got %0d/%0d expected 7", counts32[3*32 +: 32], counts4[3*4 +: 4]);
    end
    clr_valid = 1'b1; clr_idx = 4'd3; event_i = 16'h0008;
    tick();
    clr_valid = 1'b0; event_i = 16'h0000; snap = 1'b1;
    tick();
    snap = 1'b0;
    checks++;
    if (counts32[3*32 +: 32] !== 32'd0 || counts4[3*4 +: 4] !== 4'd0) begin
      failures++;
      $display("[TB] FAIL conf_clr_vs_event: got %0d/%0d expected 0", counts32[3*32 +: 32], counts4[3*4 +: 4]);
    end
    freeze = 1'b1; event_i = 16'hFFFF;
    repeat (4) tick();
    freeze = 1'b0; event_i = 16'h0000; snap = 1'b1;
    tick();
    snap = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp = (i == 0) ? 5 : (i == 15) ? 3 : 0;
      checks++;
      if (counts32[i*32 +: 32] !== 32'(exp) || counts4[i*4 +: 4] !== 4'(exp)) begin
        failures++;
        $display("[TB] FAIL conf_freeze_lane%0d: got %0d/%0d expected %0d", i, counts32[i*32 +: 32], counts4[i*4 +: 4], exp);
      end
    end
    snap = 1'b1; event_i = 16'h0002;
    tick();
    event_i = 16'h0000;
    checks++;
    if (counts32[1*32 +: 32] !== 32'd0 || counts4[1*4 +: 4] !== 4'd0) begin
      failures++;
      $display("[TB] FAIL conf_snap_excl: got %0d/%0d expected 0", counts32[1*32 +: 32], counts4[1*4 +: 4]);
    end
    tick();
    snap = 1'b0;
    checks++;
    if (counts32[1*32 +: 32] !== 32'd1 || counts4[1*4 +: 4] !== 4'd1) begin
      failures++;
      $display("[TB] FAIL conf_snap_next: got %0d/%0d expected 1", counts32[1*32 +: 32], counts4[1*4 +: 4]);
    end
  endtask

  task automatic test_sweep();
    int nbusy;
    set_idle();
    clr_all = 1'b1;
    tick();
    clr_all = 1'b0;
    repeat (17) tick();
    event_i = 16'hFFFF;
    repeat (10) tick();
    event_i = 16'h0000; snap = 1'b1;
    tick();
    snap = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (counts32[i*32 +: 32] !== 32'd10 || counts4[i*4 +: 4] !== 4'd10) begin
        failures++;
        $display("[TB] FAIL sweep_preload%0d: got %0d/%0d expected 10", i, counts32[i*32 +: 32], counts4[i*4 +: 4]);
      end
    end
    event_i = 16'hFFFF; clr_all = 1'b1;
    tick();
    clr_all = 1'b0;
    nbusy = busy32 ? 1 : 0;
    for (int c = 0; c < 40 && busy32; c++) begin
      if (c == 3) clr_all = 1'b1;
      tick();
      clr_all = 1'b0;
      if (busy32) nbusy++;
    end
    checks++;
    if (nbusy != 16) begin
      failures++;
      $display("[TB] FAIL sweep_busy_len: got %0d expected 16", nbusy);
    end
    snap = 1'b1;
    tick();
    snap = 1'b0; event_i = 16'h0000;
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (counts32[k*32 +: 32] !== 32'(15 - k) || counts4[k*4 +: 4] !== 4'(15 - k)) begin
        failures++;
        $display("[TB] FAIL sweep_lane%0d: got %0d/%0d expected %0d", k, counts32[k*32 +: 32], counts4[k*4 +: 4], 15 - k);
      end
    end
    checks++;
    if (busy32 !== 1'b0 || busy4 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sweep_no_restart: got %b/%b expected 0", busy32, busy4);
    end
  endtask

  task automatic test_rst_mid_sweep();
    set_idle();
    event_i = 16'($urandom);
    clr_all = 1'b1;
    tick();
    clr_all = 1'b0;
    repeat (4) tick();
    rst = 1'b1; snap = 1'b1;
    tick();
    rst = 1'b0; snap = 1'b0;
    checks++;
    if (busy32 !== 1'b0 || busy4 !== 1'b0 || sv32 !== 1'b0 || ovf32 !== 16'h0 || ovf4 !== 16'h0) begin
      failures++;
      $display("[TB] FAIL rstsweep_flags: got busy=%b/%b sv=%b ovf=%h/%h expected 0", busy32, busy4, sv32, ovf32, ovf4);
    end
    event_i = 16'h0000; snap = 1'b1;
    tick();
    snap = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (counts32[i*32 +: 32] !== 32'd0 || counts4[i*4 +: 4] !== 4'd0) begin
        failures++;
        $display("[TB] FAIL rstsweep_lane%0d: got %0d/%0d expected 0", i, counts32[i*32 +: 32], counts4[i*4 +: 4]);
      end
    end
    clr_all = 1'b1;
    tick();
    clr_all = 1'b0;
    checks++;
    if (busy32 !== 1'b1 || busy4 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rstsweep_reaccept: got %b/%b expected 1", busy32, busy4);
    end
    repeat (16) tick();
    checks++;
    if (busy32 !== 1'b0 || busy4 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rstsweep_done: got %b/%b expected 0", busy32, busy4);
    end
  endtask

  task automatic test_snap_stability();
    logic [31:0] e32 [16];
    logic [3:0]  e4  [16];
    set_idle();
    event_i = 16'($urandom);
    repeat (3) tick();
    snap = 1'b1;
    tick();
    snap = 1'b0;
    for (int i = 0; i < 16; i++) begin
      e32[i] = s32[i];
      e4[i]  = s4[i];
    end
    for (int c = 0; c < 10; c++) begin
      event_i = 16'($urandom);
      tick();
      checks++;
      if (sv32 !== 1'b0 || sv4 !== 1'b0) begin
        failures++;
        $display("[TB] FAIL stable_sv_c%0d: got %b/%b expected 0", c, sv32, sv4);
      end
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (counts32[i*32 +: 32] !== e32[i] || counts4[i*4 +: 4] !== e4[i]) begin
          failures++;
          $display("[TB] FAIL stable_c%0d_lane%0d: got %0d/%0d expected %0d/%0d", c, i, counts32[i*32 +: 32], counts4[i*4 +: 4], e32[i], e4[i]);
        end
      end
    end
    event_i = 16'h0000;
  endtask

  task automatic test_random();
    set_idle();
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      freeze    = ($urandom_range(0, 7) == 0);
      clr_valid = ($urandom_range(0, 5) == 0);
      clr_idx   = 4'($urandom);
      clr_all   = ($urandom_range(0, 19) == 0);
      snap      = ($urandom_range(0, 2) == 0);
      event_i   = 16'($urandom) | 16'($urandom);
      tick();
      checks++;
      if (sv32 !== msv || sv4 !== msv || busy32 !== msweep || busy4 !== msweep) begin
        failures++;
        $display("[TB] FAIL rand_ctl_c%0d: got sv=%b/%b busy=%b/%b expected sv=%b busy=%b", c, sv32, sv4, busy32, busy4, msv, msweep);
      end
      checks++;
      if (ovf32 !== mo32 || ovf4 !== mo4) begin
        failures++;
        $display("[TB] FAIL rand_ovf_c%0d: got %h/%h expected %h/%h", c, ovf32, ovf4, mo32, mo4);
      end
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (counts32[i*32 +: 32] !== s32[i] || counts4[i*4 +: 4] !== s4[i]) begin
          failures++;
          $display("[TB] FAIL rand_c%0d_lane%0d: got %0d/%0d expected %0d/%0d", c, i, counts32[i*32 +: 32], counts4[i*4 +: 4], s32[i], s4[i]);
        end
      end
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    test_reset();
    test_counting();
    test_saturation();
    test_conflicts();
    test_sweep();
    test_rst_mid_sweep();
    test_snap_stability();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
